// File: rtl/v850_pkg.sv
// Shared V850 instruction-length types, opcode constants and the length classifier.
package v850_pkg;

  typedef enum logic [1:0] {
    ILEN_NONE = 2'd0,
    ILEN_16   = 2'd1,
    ILEN_32   = 2'd2,
    ILEN_48   = 2'd3
  } ilen_t;

  localparam logic [5:0] OP6_MOV_IMM32 = 6'b110001;
  localparam logic [5:0] OP6_JR_D32    = 6'b010111;
  localparam logic [5:0] OP6_JMP_D32   = 6'b110111;

  function automatic ilen_t ilen_of(input logic [15:0] h0);
    if ((h0[15:11] == 5'b00000) &&
        ((h0[10:5] == OP6_MOV_IMM32) || (h0[10:5] == OP6_JR_D32) ||
         (h0[10:5] == OP6_JMP_D32)))
      return ILEN_48;
    else if (h0[10:9] == 2'b11)
      return ILEN_32;
    else
      return ILEN_16;
  endfunction

endpackage

// File: rtl/v850_ilen_decode.sv
// Combinational instruction length classifier from the first halfword.
module v850_ilen_decode
  import v850_pkg::*;
(
  input  logic [15:0] h0,
  output ilen_t       len
);

  assign len = ilen_of(h0);

endmodule

// File: rtl/v850_fetch_align_queue.sv
// Halfword prefetch queue that aligns variable-length V850 instructions for the decoder.
module v850_fetch_align_queue
  import v850_pkg::*;
#(
  parameter int unsigned FETCH_HW = 2,
  parameter int unsigned DEPTH_HW = 8,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic [31:0]           flush_pc,
  input  logic                  fetch_valid,
  output logic                  fetch_ready,
  input  logic [16*FETCH_HW-1:0] fetch_data,
  output logic                  dec_valid,
  input  logic                  dec_ready,
  output logic [47:0]           dec_instr,
  output logic [1:0]            dec_len,
  output logic [31:0]           dec_pc
);

  localparam int unsigned AW  = $clog2(DEPTH_HW);
  localparam int unsigned CW  = $clog2(DEPTH_HW + 1);
  localparam int unsigned SKW = (FETCH_HW > 1) ? $clog2(FETCH_HW) : 1;

  logic [15:0]    mem     [DEPTH_HW];
  logic           wr_en   [DEPTH_HW];
  logic [15:0]    wr_data [DEPTH_HW];

  logic [AW-1:0]  head;
  logic [CW-1:0]  count;
  logic [SKW-1:0] skip;
  logic [31:0]    pc;

  logic [AW-1:0]  tail;
  logic [15:0]    h0, h1, h2;
  ilen_t          head_len;
  logic [CW-1:0]  len_hw;
  logic [CW-1:0]  push_n;
  logic           push, pop;
  logic [SKW-1:0] flush_skip;
  logic [CW-1:0]  count_next;

  assign tail = head + AW'(count);
  assign h0   = mem[head];
  assign h1   = mem[head + AW'(1)];
  assign h2   = mem[head + AW'(2)];

  v850_ilen_decode u_ilen_decode (
    .h0  (h0),
    .len (head_len)
  );

  assign len_hw = {{(CW-2){1'b0}}, head_len};

  // count guard keeps the head classification of unwritten storage out of dec_valid
  assign dec_valid   = (count != '0) && (count >= len_hw);
  assign fetch_ready = (count <= CW'(DEPTH_HW - FETCH_HW));

  assign dec_len   = dec_valid ? head_len : ILEN_NONE;
  assign dec_instr = {(dec_len == ILEN_48) ? h2 : 16'h0000,
                      ((dec_len == ILEN_32) || (dec_len == ILEN_48)) ? h1 : 16'h0000,
                      dec_valid ? h0 : 16'h0000};
  assign dec_pc    = pc;

  assign push   = fetch_valid && fetch_ready && !flush;
  assign pop    = dec_valid && dec_ready && !flush;
  assign push_n = CW'(FETCH_HW) - CW'(skip);

  assign flush_skip = SKW'((flush_pc >> 1) & 32'(FETCH_HW - 1));
  assign count_next = count + (push ? push_n : '0) - (pop ? len_hw : '0);

  // Beat halfwords at index >= skip land contiguously from the tail.
  always_comb begin
    for (int unsigned i = 0; i < DEPTH_HW; i++) begin
      wr_en[i]   = 1'b0;
      wr_data[i] = '0;
    end
    if (push) begin
      for (int unsigned k = 0; k < FETCH_HW; k++) begin
        if (k >= 32'(skip)) begin
          wr_en[tail + AW'(k) - AW'(skip)]   = 1'b1;
          wr_data[tail + AW'(k) - AW'(skip)] = fetch_data[16*k +: 16];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < DEPTH_HW; i++) begin
      if (wr_en[i]) mem[i] <= wr_data[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      count <= '0;
      skip  <= '0;
      pc    <= RESET_PC;
    end else if (flush) begin
      count <= '0;
      skip  <= flush_skip;
      pc    <= {flush_pc[31:1], 1'b0};
    end else begin
      count <= count_next;
      if (push) skip <= '0;
      if (pop) begin
        head <= head + AW'(len_hw);
        pc   <= pc + 32'(len_hw) + 32'(len_hw);
      end
    end
  end

endmodule

// File: tb/tb_v850_fetch_align_queue.sv
// Directed bench for the fetch align queue: decode lengths, skip, backpressure, flush, reset.
module tb_v850_fetch_align_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [31:0] flush_pc;
  logic        fetch_valid;
  logic        fetch_ready;
  logic [31:0] fetch_data;
  logic        dec_valid;
  logic        dec_ready;
  logic [47:0] dec_instr;
  logic [1:0]  dec_len;
  logic [31:0] dec_pc;

  int checks = 0;
  int errors = 0;

  v850_fetch_align_queue #(
    .FETCH_HW (2),
    .DEPTH_HW (8),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .flush_pc    (flush_pc),
    .fetch_valid (fetch_valid),
    .fetch_ready (fetch_ready),
    .fetch_data  (fetch_data),
    .dec_valid   (dec_valid),
    .dec_ready   (dec_ready),
    .dec_instr   (dec_instr),
    .dec_len     (dec_len),
    .dec_pc      (dec_pc)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_head(input string tag, input logic [47:0] instr, input logic [1:0] len,
                          input logic [31:0] pc);
    chk({tag, "_valid"}, 64'(dec_valid), 64'(1));
    chk({tag, "_instr"}, 64'(dec_instr), 64'(instr));
    chk({tag, "_len"},   64'(dec_len),   64'(len));
    chk({tag, "_pc"},    64'(dec_pc),    64'(pc));
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; flush_pc = '0;
    fetch_valid = 1'b0; fetch_data = '0; dec_ready = 1'b0;
    tick(); tick();
    chk("rst_valid", 64'(dec_valid), 64'(0));
    chk("rst_len",   64'(dec_len),   64'(0));
    chk("rst_instr", 64'(dec_instr), 64'(0));
    chk("rst_pc",    64'(dec_pc),    64'(0));
    chk("rst_fready", 64'(fetch_ready), 64'(1));
    rst_n = 1'b1;
    tick();

    // DI: 32-bit instruction in one beat
    fetch_valid = 1'b1; fetch_data = 32'h0160_07E0;
    tick();
    fetch_valid = 1'b0;
    chk_head("di", 48'h0000_0160_07E0, 2'd2, 32'h0);
    dec_ready = 1'b1;
    tick();
    dec_ready = 1'b0;
    chk("di_pop_valid", 64'(dec_valid), 64'(0));
    chk("di_pop_pc",    64'(dec_pc),    64'(32'h4));
    chk("di_pop_count", 64'(dut.count), 64'(0));

    // two ADDs, consumed back to back
    flush = 1'b1; flush_pc = 32'h0;
    tick();
    flush = 1'b0;
    fetch_valid = 1'b1; fetch_data = 32'h11C1_11C1; dec_ready = 1'b1;
    tick();
    fetch_valid = 1'b0;
    chk_head("add0", 48'h11C1, 2'd1, 32'h0);
    tick();
    chk_head("add1", 48'h11C1, 2'd1, 32'h2);
    tick();
    chk("add_empty", 64'(dec_valid), 64'(0));
    dec_ready = 1'b0;

    // MOV imm32 split across two beats
    flush = 1'b1; flush_pc = 32'h0;
    tick();
    flush = 1'b0;
    fetch_valid = 1'b1; fetch_data = 32'h5678_0625;
    tick();
    chk("mov_partial", 64'(dec_valid), 64'(0));
    fetch_data = 32'h0000_1234;
    tick();
    fetch_valid = 1'b0;
    chk_head("mov", 48'h1234_5678_0625, 2'd3, 32'h0);
    dec_ready = 1'b1;
    tick();
    chk_head("resid", 48'h0, 2'd1, 32'h6);
    tick();
    dec_ready = 1'b0;
    chk("resid_gone", 64'(dec_valid), 64'(0));
    chk("resid_pc",   64'(dec_pc),    64'(32'h8));

    // flush to odd halfword of a beat: low halfword skipped
    flush = 1'b1; flush_pc = 32'h0000_1003;
    tick();
    flush = 1'b0;
    chk("fl_valid", 64'(dec_valid), 64'(0));
    chk("fl_pc",    64'(dec_pc),    64'(32'h1002));
    fetch_valid = 1'b1; fetch_data = 32'h11C1_AAAA;
    tick();
    fetch_valid = 1'b0;
    chk_head("skip", 48'h11C1, 2'd1, 32'h1002);
    chk("skip_count", 64'(dut.count), 64'(1));
    dec_ready = 1'b1;
    tick();
    dec_ready = 1'b0;
    chk("skip_empty", 64'(dec_valid), 64'(0));
    chk("skip_pc",    64'(dec_pc),    64'(32'h1004));

    // backpressure: fill to 8 with no consumer
    fetch_valid = 1'b1; fetch_data = 32'h11C1_11C1;
    tick();
    chk("bp1_fready", 64'(fetch_ready), 64'(1));
    chk("bp1_count",  64'(dut.count),   64'(2));
    tick();
    chk("bp2_fready", 64'(fetch_ready), 64'(1));
    tick();
    chk("bp3_fready", 64'(fetch_ready), 64'(1));
    chk("bp3_count",  64'(dut.count),   64'(6));
    tick();
    chk("bp4_fready", 64'(fetch_ready), 64'(0));
    chk("bp4_count",  64'(dut.count),   64'(8));
    tick();
    chk("bp_hold_count", 64'(dut.count), 64'(8));
    dec_ready = 1'b1;
    tick();
    chk("pop1_count",  64'(dut.count),   64'(7));
    chk("pop1_fready", 64'(fetch_ready), 64'(0));
    chk("pop1_pc",     64'(dec_pc),      64'(32'h1006));
    tick();
    chk("pop2_count",  64'(dut.count),   64'(6));
    chk("pop2_fready", 64'(fetch_ready), 64'(1));
    chk("pop2_pc",     64'(dec_pc),      64'(32'h1008));
    tick();
    fetch_valid = 1'b0;
    chk("pushpop_count", 64'(dut.count), 64'(7));
    chk("pushpop_pc",    64'(dec_pc),    64'(32'h100A));
    tick(); tick();
    chk("five_count", 64'(dut.count), 64'(5));
    chk_head("five", 48'h11C1, 2'd1, 32'h100E);

    // flush wins over simultaneous push and pop
    flush = 1'b1; flush_pc = 32'h0000_2000;
    fetch_valid = 1'b1; fetch_data = 32'h11C1_11C1; dec_ready = 1'b1;
    tick();
    flush = 1'b0; fetch_valid = 1'b0; dec_ready = 1'b0;
    chk("flp_valid",  64'(dec_valid),   64'(0));
    chk("flp_fready", 64'(fetch_ready), 64'(1));
    chk("flp_pc",     64'(dec_pc),      64'(32'h2000));
    chk("flp_count",  64'(dut.count),   64'(0));
    fetch_valid = 1'b1; fetch_data = 32'h3333_11C1;
    tick();
    fetch_valid = 1'b0;
    chk_head("after_fl", 48'h11C1, 2'd1, 32'h2000);
    chk("after_fl_count", 64'(dut.count), 64'(2));

    // asynchronous reset mid-operation
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid",  64'(dec_valid),   64'(0));
    chk("arst_pc",     64'(dec_pc),      64'(0));
    chk("arst_fready", 64'(fetch_ready), 64'(1));
    chk("arst_instr",  64'(dec_instr),   64'(0));
    tick();
    rst_n = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
